// File: rtl/uart_rx_frame.sv
// UART receive engine: start validation, data capture, parity and stop checks.
// Samples mid-bit on the oversampled baud tick and reports errored frames too.
module uart_rx_frame #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    input  logic                 tick,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [TW-1:0] MID_START = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] MID_BIT   = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP,
        S_WAIT_HIGH
    } state_e;

    state_e                 state_q;
    logic                   rx_meta_q;
    logic                   rx_s_q;
    logic                   rx_dly_q;
    logic [TW-1:0]          tick_cnt_q;
    logic [BW-1:0]          bit_cnt_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic                   par_bad_q;
    logic                   fr_bad_q;

    logic mid_start;
    logic mid_bit;
    logic stop_bad;
    logic exp_par;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_dly_q  <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            rx_dly_q  <= rx_s_q;
        end
    end

    assign mid_start = tick && (tick_cnt_q == MID_START);
    assign mid_bit   = tick && (tick_cnt_q == MID_BIT);
    assign stop_bad  = fr_bad_q | ~rx_s_q;
    assign exp_par   = (PARITY == 1) ? ~(^shift_q) : (^shift_q);
    assign busy      = (state_q != S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_bad_q  <= 1'b0;
            fr_bad_q   <= 1'b0;
            data_out   <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (tick && state_q != S_IDLE) begin
                tick_cnt_q <= tick_cnt_q + 1'b1;
            end
            unique case (state_q)
                S_IDLE: begin
                    if (rx_dly_q && !rx_s_q) begin
                        tick_cnt_q <= '0;
                        par_bad_q  <= 1'b0;
                        fr_bad_q   <= 1'b0;
                        state_q    <= S_START;
                    end
                end
                S_START: begin
                    if (mid_start) begin
                        if (rx_s_q) begin
                            state_q <= S_IDLE;
                        end else begin
                            tick_cnt_q <= '0;
                            bit_cnt_q  <= '0;
                            state_q    <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (mid_bit) begin
                        tick_cnt_q <= '0;
                        shift_q    <= {rx_s_q, shift_q[DATA_BITS-1:1]};
                        if (bit_cnt_q == LAST_DATA) begin
                            bit_cnt_q <= '0;
                            state_q   <= (PARITY != 0) ? S_PAR : S_STOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                end
                S_PAR: begin
                    if (mid_bit) begin
                        tick_cnt_q <= '0;
                        par_bad_q  <= rx_s_q ^ exp_par;
                        state_q    <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (mid_bit) begin
                        tick_cnt_q <= '0;
                        fr_bad_q   <= stop_bad;
                        if (bit_cnt_q == LAST_STOP) begin
                            bit_cnt_q  <= '0;
                            data_out   <= shift_q;
                            parity_err <= (PARITY != 0) && par_bad_q;
                            frame_err  <= stop_bad;
                            valid      <= 1'b1;
                            // a low stop may be a break: wait for idle line
                            state_q    <= stop_bad ? S_WAIT_HIGH : S_IDLE;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                end
                S_WAIT_HIGH: begin
                    if (rx_s_q) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
